// File: rtl/page_table.sv
// page_table: single-level virtual-to-physical page table with
// on-demand page allocation and a host write port.
//
// Parameters
//   ADDR_W   : virtual / physical address width
//   OFFSET_W : page-offset width (page number = ADDR_W-OFFSET_W bits)
// Ports
//   clk           : clock, all state updates on rising edge
//   rst           : asynchronous active-high reset
//   is_lock       : 1 = hold output, 0 = translate virtual_addr
//   virtual_addr  : {vpn, offset} to translate
//   physical_addr : registered translated address
//   page_fault    : registered one-cycle pulse on allocating miss
//   wr_en         : host write strobe
//   wr_vpn        : host write page number
//   wr_ppn        : host write physical page number
module page_table #(
    parameter int ADDR_W   = 8,
    parameter int OFFSET_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       is_lock,
    input  logic [ADDR_W-1:0]          virtual_addr,
    output logic [ADDR_W-1:0]          physical_addr,
    output logic                       page_fault,
    input  logic                       wr_en,
    input  logic [ADDR_W-OFFSET_W-1:0] wr_vpn,
    input  logic [ADDR_W-OFFSET_W-1:0] wr_ppn
);

    localparam int PN_W = ADDR_W - OFFSET_W;
    localparam int N    = 1 << PN_W;

    logic            valid [N];
    logic [PN_W-1:0] ppn   [N];
    logic [PN_W-1:0] free_ptr;

    logic [PN_W-1:0]     vpn;
    logic [OFFSET_W-1:0] off;

    assign vpn = virtual_addr[ADDR_W-1:OFFSET_W];
    assign off = virtual_addr[OFFSET_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                valid[i] <= 1'b0;
                ppn[i]   <= '0;
            end
            free_ptr      <= '0;
            physical_addr <= '0;
            page_fault    <= 1'b0;
        end else begin
            page_fault <= 1'b0;
            if (!is_lock) begin
                if (valid[vpn]) begin
                    physical_addr <= {ppn[vpn], off};
                end else begin
                    valid[vpn]    <= 1'b1;
                    ppn[vpn]      <= free_ptr;
                    physical_addr <= {free_ptr, off};
                    page_fault    <= 1'b1;
                    // wraps silently; physical pages may alias
                    free_ptr      <= free_ptr + 1'b1;
                end
            end
            // Placed last so a host write to the same VPN as an
            // allocating miss overrides the stored entry. Lookups
            // above read the pre-edge table, so translation is
            // unaffected by a same-edge write.
            if (wr_en) begin
                valid[wr_vpn] <= 1'b1;
                ppn[wr_vpn]   <= wr_ppn;
            end
        end
    end

endmodule

// File: tb/tb_page_table.sv
// tb_page_table: directed plus randomized check of page_table
// against a behavioural table model.
module tb_page_table;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       is_lock = 1'b1;
    logic [7:0] virtual_addr = '0;
    logic [7:0] physical_addr;
    logic       page_fault;
    logic       wr_en = 1'b0;
    logic [3:0] wr_vpn = '0;
    logic [3:0] wr_ppn = '0;

    int n_chk = 0;
    int n_fail = 0;

    page_table #(.ADDR_W(8), .OFFSET_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .is_lock(is_lock),
        .virtual_addr(virtual_addr),
        .physical_addr(physical_addr),
        .page_fault(page_fault),
        .wr_en(wr_en),
        .wr_vpn(wr_vpn),
        .wr_ppn(wr_ppn)
    );

    always #5 clk = ~clk;

    // Behavioural model: a map from page number to physical page,
    // and a count of allocations made since reset.
    bit         m_valid [16];
    int         m_page  [16];
    int         n_alloc;
    int         e_pa;
    int         e_pf;

    always @(posedge clk or posedge rst) begin
        int pg;
        int of;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_page[i]  = 0;
            end
            n_alloc = 0;
            e_pa = 0;
            e_pf = 0;
        end else begin
            pg = int'(virtual_addr) / 16;
            of = int'(virtual_addr) % 16;
            e_pf = 0;
            if (!is_lock) begin
                if (m_valid[pg]) begin
                    e_pa = m_page[pg] * 16 + of;
                end else begin
                    m_valid[pg] = 1;
                    m_page[pg]  = n_alloc % 16;
                    e_pa = (n_alloc % 16) * 16 + of;
                    e_pf = 1;
                    n_alloc = n_alloc + 1;
                end
            end
            if (wr_en) begin
                m_valid[wr_vpn] = 1;
                m_page[wr_vpn]  = int'(wr_ppn);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_pa", {24'd0, physical_addr}, e_pa);
        chk("model_pf", {31'd0, page_fault}, e_pf);
    end

    task automatic go(input logic l, input logic [7:0] a,
                      input logic w, input logic [3:0] v,
                      input logic [3:0] p);
        is_lock = l;
        virtual_addr = a;
        wr_en = w;
        wr_vpn = v;
        wr_ppn = p;
        @(posedge clk);
        #1;
        is_lock = 1'b1;
        wr_en = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [7:0] pa,
                       input logic pf);
        chk({nm, "_pa"}, {24'd0, physical_addr}, {24'd0, pa});
        chk({nm, "_pf"}, {31'd0, page_fault}, {31'd0, pf});
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        lit("async_rst", 8'h00, 1'b0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 8'h00, 1'b0);
        rst = 1'b0;

        go(0, 8'h35, 0, 4'h0, 4'h0);
        lit("first_miss", 8'h05, 1'b1);
        go(0, 8'h3A, 0, 4'h0, 4'h0);
        lit("hit", 8'h0A, 1'b0);
        go(1, 8'h3A, 1, 4'h7, 4'hC);
        lit("locked_wr", 8'h0A, 1'b0);
        go(0, 8'h71, 0, 4'h0, 4'h0);
        lit("host_map", 8'hC1, 1'b0);
        go(1, 8'h71, 0, 4'h0, 4'h0);
        lit("lock_hold", 8'hC1, 1'b0);
        go(1, 8'h22, 0, 4'h0, 4'h0);
        lit("lock_va_chg", 8'hC1, 1'b0);
        go(0, 8'h22, 0, 4'h0, 4'h0);
        lit("no_lock_alloc", 8'h12, 1'b1);

        go(0, 8'h45, 1, 4'h4, 4'h9);
        lit("miss_wr_same", 8'h25, 1'b1);
        go(0, 8'h46, 0, 4'h0, 4'h0);
        lit("wr_wins", 8'h96, 1'b0);
        go(0, 8'h3B, 1, 4'h3, 4'hE);
        lit("pre_edge_read", 8'h0B, 1'b0);
        go(0, 8'h3B, 0, 4'h0, 4'h0);
        lit("post_wr", 8'hEB, 1'b0);

        mid_reset();
        go(0, 8'h73, 0, 4'h0, 4'h0);
        lit("refault", 8'h03, 1'b1);

        mid_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] pg;
            pg = 4'(i);
            go(0, {pg, 4'h5}, 0, 4'h0, 4'h0);
            lit("alloc_seq", {pg, 4'h5}, 1'b1);
        end
        go(0, 8'hF6, 0, 4'h0, 4'h0);
        lit("full_hit", 8'hF6, 1'b0);
        mid_reset();
        go(0, 8'hA1, 0, 4'h0, 4'h0);
        lit("wrap_alloc", 8'h01, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                mid_reset();
                @(posedge clk);
                #1;
            end else begin
                go($urandom_range(0, 3) == 0,
                   8'($urandom),
                   $urandom_range(0, 5) == 0,
                   4'($urandom),
                   4'($urandom));
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/page_table.md
PAGE_TABLE -- requirements
Module: page_table

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the width of the virtual and physical addresses.
REQ-002 The block SHALL have parameter OFFSET_W, default 4, meaning the page-offset width; the page number is ADDR_W-OFFSET_W bits (default 4, giving 16 pages).
REQ-003 The block SHALL have a single clock, clk, an input of width 1, with all state updated on its rising edge.
REQ-004 The block SHALL have reset, rst, an input of width 1; rst is asynchronous and active-high.
REQ-005 The block SHALL have is_lock, an input of width 1: 1 = hold the output; 0 = perform a lookup on this edge.
REQ-006 The block SHALL have virtual_addr, an input of width ADDR_W: [ADDR_W-1:OFFSET_W] is the VPN; [OFFSET_W-1:0] is the offset.
REQ-007 The block SHALL have physical_addr, an output of width ADDR_W: the registered translated address.
REQ-008 The block SHALL have page_fault, an output of width 1: a registered one-cycle pulse when the last lookup missed and allocated a page.
REQ-009 The block SHALL have wr_en, an input of width 1: a host write strobe that installs a mapping.
REQ-010 The block SHALL have wr_vpn, an input of width ADDR_W-OFFSET_W: the VPN to write.
REQ-011 The block SHALL have wr_ppn, an input of width ADDR_W-OFFSET_W: the PPN to write.

Function
REQ-012 The table SHALL hold 2^(ADDR_W-OFFSET_W) entries, each a valid bit plus a PPN of width ADDR_W-OFFSET_W, indexed by VPN.
REQ-013 The block SHALL contain a free-page pointer free_ptr of width ADDR_W-OFFSET_W for on-demand allocation.
REQ-014 With is_lock=1 at a rising edge, physical_addr SHALL hold its value, page_fault SHALL be driven to 0, and the table SHALL not change, except through the wr_en write in REQ-018.
REQ-015 Lookup hit (is_lock=0, entry[VPN] valid): on the next edge, physical_addr SHALL be {entry[VPN].ppn, offset} and page_fault SHALL be 0.
REQ-016 Lookup miss (is_lock=0, entry[VPN] invalid) SHALL cause, on the same edge:
  - entry[VPN] set to valid with ppn=free_ptr;
  - physical_addr set to {free_ptr, offset};
  - page_fault set to 1;
  - free_ptr incremented.
REQ-017 free_ptr SHALL wrap modulo 2^(ADDR_W-OFFSET_W), from all-ones to 0, with no full indication; after a wrap, aliasing of physical pages is permitted.
REQ-018 wr_en=1 at an edge SHALL set entry[wr_vpn] to valid with ppn=wr_ppn, regardless of is_lock; free_ptr SHALL be unchanged by host writes.
REQ-019 A simultaneous wr_en and lookup SHALL use the pre-edge table contents for the translation.
REQ-020 If the wr_vpn of REQ-019 equals the lookup VPN on a miss, the host write SHALL win for the stored entry, while the output and free_ptr SHALL still follow the miss rule.
REQ-021 Translation latency SHALL be 1 clock: the result is valid after the first rising edge with is_lock=0.
REQ-022 The offset bits SHALL always pass through unchanged.
REQ-023 The block SHALL have no combinational path from inputs to outputs.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for a clock edge:
  - clear all valid bits and PPNs to 0;
  - set free_ptr to 0;
  - set physical_addr to 0;
  - set page_fault to 0.
REQ-025 Reset mid-operation SHALL discard any lookup or write in progress; the first edge after deassertion SHALL behave per REQ-014 to REQ-020 with an empty table.

Verification
REQ-026 Reset, then is_lock=0 with va=0x35 -> physical_addr=0x05, page_fault=1; entry[3] valid, ppn=0; free_ptr=1.
REQ-027 Then va=0x3A with is_lock=0 -> physical_addr=0x0A, page_fault=0 (hit).
REQ-028 Host write wr_vpn=7, wr_ppn=0xC, then lookup va=0x71 -> physical_addr=0xC1, page_fault=0; free_ptr unchanged.
REQ-029 is_lock=1 while va changes from 0x71 to 0x22 -> physical_addr stays 0xC1; entry[2] remains invalid.
REQ-030 17 misses on distinct VPNs from reset (VPN 0..15, then re-miss after a host-cleared rst) -> PPNs issued 0..15 in order, then free_ptr wraps to 0.
REQ-031 rst pulsed between clock edges after several allocations -> outputs 0 immediately; the next lookup of a previously mapped VPN faults with ppn=0.
